// File: rtl/pd_power_responder.sv
// pd_power_responder
// Domain-side responder for the iso_en/ret_en/pse power interface. Models the
// power switch ramp, keeps the last domain result in a retention register
// across power-off, clamps outputs while isolated or unpowered, and flags
// sticky protocol errors back to the controller side.
module pd_power_responder #(
    parameter int                 WIDTH       = 32,
    parameter int                 RAMP_CYCLES = 4,
    parameter logic [WIDTH-1:0]   ISO_VAL     = '0
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             iso_en,
    input  logic             ret_en,
    input  logic             pse,
    input  logic [WIDTH-1:0] S_in,
    input  logic             C_in,
    output logic [WIDTH-1:0] S_out,
    output logic             C_out,
    output logic             pwr_good,
    output logic             ret_valid,
    output logic             prot_err,
    output logic [2:0]       state_o
);

    localparam int               CNT_W    = (RAMP_CYCLES > 1) ? $clog2(RAMP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RAMP_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_ON    = 3'd0,
        ST_ISO   = 3'd1,
        ST_RET   = 3'd2,
        ST_DOWN  = 3'd3,
        ST_OFF   = 3'd4,
        ST_UP    = 3'd5,
        ST_READY = 3'd6
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   ret_reg_q, ret_reg_d;
    logic             ret_valid_q, ret_valid_d;
    logic             prot_err_q, prot_err_d;
    logic [WIDTH-1:0] s_out_q, s_out_d;
    logic             c_out_q, c_out_d;

    // Next-state, ramp counter, retention capture and protocol error detection
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ret_reg_d   = ret_reg_q;
        ret_valid_d = ret_valid_q;
        prot_err_d  = prot_err_q;

        case (state_q)
            ST_ON: begin
                // Losing power without isolation first is illegal; pse wins over iso_en.
                if (!pse) begin
                    state_d    = ST_DOWN;
                    cnt_d      = '0;
                    prot_err_d = 1'b1;
                end else if (iso_en) begin
                    state_d = ST_ISO;
                end
            end
            ST_ISO: begin
                if (!pse) begin
                    state_d    = ST_DOWN;
                    cnt_d      = '0;
                    prot_err_d = 1'b1;
                end else if (ret_en) begin
                    state_d     = ST_RET;
                    ret_reg_d   = {C_in, S_in};
                    ret_valid_d = 1'b1;
                end else if (!iso_en) begin
                    state_d = ST_ON;
                end
            end
            ST_RET: begin
                if (!pse) begin
                    state_d = ST_DOWN;
                    cnt_d   = '0;
                end else if (!ret_en) begin
                    // Save aborted: the captured value stays valid.
                    state_d = ST_ISO;
                end else if (!iso_en) begin
                    prot_err_d = 1'b1;
                end
            end
            ST_DOWN: begin
                // The down ramp always completes, whatever pse does meanwhile.
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_OFF: begin
                if (pse) begin
                    state_d = ST_UP;
                    cnt_d   = '0;
                end else if (!iso_en) begin
                    prot_err_d = 1'b1;
                end
            end
            ST_UP: begin
                if (!pse) begin
                    state_d = ST_DOWN;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_READY: begin
                if (!pse) begin
                    state_d = ST_DOWN;
                    cnt_d   = '0;
                end else if (!ret_en && !iso_en) begin
                    state_d = ST_ON;
                end
            end
            default: begin
                state_d = ST_ON;
                cnt_d   = '0;
            end
        endcase

        // Retained data is consumed (or discarded) whenever the domain goes live.
        if (state_d == ST_ON) begin
            ret_valid_d = 1'b0;
        end
    end

    // Output register: live data in ON, one restore cycle out of READY, clamp otherwise
    always_comb begin
        s_out_d = ISO_VAL;
        c_out_d = 1'b0;
        if (state_d == ST_ON) begin
            if (state_q == ST_READY) begin
                if (ret_valid_q) begin
                    {c_out_d, s_out_d} = ret_reg_q;
                end else begin
                    s_out_d = ISO_VAL;
                    c_out_d = 1'b0;
                end
            end else begin
                s_out_d = S_in;
                c_out_d = C_in;
            end
        end
    end

    // State and data registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= ST_ON;
            cnt_q       <= '0;
            ret_reg_q   <= '0;
            ret_valid_q <= 1'b0;
            prot_err_q  <= 1'b0;
            s_out_q     <= '0;
            c_out_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ret_reg_q   <= ret_reg_d;
            ret_valid_q <= ret_valid_d;
            prot_err_q  <= prot_err_d;
            s_out_q     <= s_out_d;
            c_out_q     <= c_out_d;
        end
    end

    assign S_out     = s_out_q;
    assign C_out     = c_out_q;
    assign ret_valid = ret_valid_q;
    assign prot_err  = prot_err_q;
    assign state_o   = state_q;
    assign pwr_good  = (state_q == ST_ON) || (state_q == ST_ISO) ||
                       (state_q == ST_RET) || (state_q == ST_READY);

endmodule

// File: tb/tb_pd_power_responder.sv
// tb_pd_power_responder
// Directed vector table for reset, live data, isolation/retention round trips
// and the full power-down/up cycle, followed by hand sequences for protocol
// errors, reset while off and ramp corner cases.
module tb_pd_power_responder;

    logic        CLK;
    logic        RST_N;
    logic        iso_en;
    logic        ret_en;
    logic        pse;
    logic [31:0] S_in;
    logic        C_in;
    logic [31:0] S_out;
    logic        C_out;
    logic        pwr_good;
    logic        ret_valid;
    logic        prot_err;
    logic [2:0]  state_o;

    int total;
    int bad;

    pd_power_responder #(
        .WIDTH      (32),
        .RAMP_CYCLES(4),
        .ISO_VAL    (32'h0)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .iso_en   (iso_en),
        .ret_en   (ret_en),
        .pse      (pse),
        .S_in     (S_in),
        .C_in     (C_in),
        .S_out    (S_out),
        .C_out    (C_out),
        .pwr_good (pwr_good),
        .ret_valid(ret_valid),
        .prot_err (prot_err),
        .state_o  (state_o)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        rn;
        logic        iso;
        logic        ret;
        logic        pse;
        logic [31:0] s;
        logic        c;
        logic [2:0]  st;
        logic [31:0] so;
        logic        co;
        logic        pg;
        logic        rv;
        logic        pe;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mv(logic rn, logic iso, logic ret, logic p, logic [31:0] s, logic c,
                                logic [2:0] st, logic [31:0] so, logic co, logic pg, logic rv,
                                logic pe);
        vec_t v;
        v.rn = rn; v.iso = iso; v.ret = ret; v.pse = p; v.s = s; v.c = c;
        v.st = st; v.so = so; v.co = co; v.pg = pg; v.rv = rv; v.pe = pe;
        return v;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(logic rn, logic iso, logic ret, logic p, logic [31:0] s, logic c);
        RST_N  = rn;
        iso_en = iso;
        ret_en = ret;
        pse    = p;
        S_in   = s;
        C_in   = c;
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_out(string tag, logic [2:0] st, logic [31:0] so, logic co,
                              logic pg, logic rv, logic pe);
        chk({tag, ".state"},     64'(state_o),   64'(st));
        chk({tag, ".S_out"},     64'(S_out),     64'(so));
        chk({tag, ".C_out"},     64'(C_out),     64'(co));
        chk({tag, ".pwr_good"},  64'(pwr_good),  64'(pg));
        chk({tag, ".ret_valid"}, 64'(ret_valid), 64'(rv));
        chk({tag, ".prot_err"},  64'(prot_err),  64'(pe));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        total  = 0;
        bad    = 0;
        RST_N  = 1'b0;
        iso_en = 1'b0;
        ret_en = 1'b0;
        pse    = 1'b1;
        S_in   = '0;
        C_in   = 1'b0;

        // reset, live data
        vecs.push_back(mv(0,0,0,1,32'h12345678,0, 3'd0,32'h0,       0,1,0,0));
        vecs.push_back(mv(1,0,0,1,32'h12345678,0, 3'd0,32'h12345678,0,1,0,0));
        // ISO, RET, abort back to ISO, release to ON
        vecs.push_back(mv(1,1,0,1,32'hA5A5A5A5,1, 3'd1,32'h0,       0,1,0,0));
        vecs.push_back(mv(1,1,1,1,32'hA5A5A5A5,1, 3'd2,32'h0,       0,1,1,0));
        vecs.push_back(mv(1,1,0,1,32'hA5A5A5A5,1, 3'd1,32'h0,       0,1,1,0));
        vecs.push_back(mv(1,0,0,1,32'h0F0F0F0F,0, 3'd0,32'h0F0F0F0F,0,1,0,0));
        vecs.push_back(mv(1,0,0,1,32'h11111111,1, 3'd0,32'h11111111,1,1,0,0));
        // full power cycle with retention of DEADBEEF/1
        vecs.push_back(mv(1,1,0,1,32'hDEADBEEF,1, 3'd1,32'h0,       0,1,0,0));
        vecs.push_back(mv(1,1,1,1,32'hDEADBEEF,1, 3'd2,32'h0,       0,1,1,0));
        vecs.push_back(mv(1,1,1,0,32'h0BADF00D,0, 3'd3,32'h0,       0,0,1,0));
        vecs.push_back(mv(1,1,1,0,32'h0BADF00D,0, 3'd3,32'h0,       0,0,1,0));
        vecs.push_back(mv(1,1,1,0,32'h0BADF00D,0, 3'd3,32'h0,       0,0,1,0));
        vecs.push_back(mv(1,1,1,0,32'h0BADF00D,0, 3'd3,32'h0,       0,0,1,0));
        vecs.push_back(mv(1,1,1,0,32'h0BADF00D,0, 3'd4,32'h0,       0,0,1,0));
        vecs.push_back(mv(1,1,1,1,32'h0BADF00D,0, 3'd5,32'h0,       0,0,1,0));
        vecs.push_back(mv(1,1,1,1,32'h0BADF00D,0, 3'd5,32'h0,       0,0,1,0));
        vecs.push_back(mv(1,1,1,1,32'h0BADF00D,0, 3'd5,32'h0,       0,0,1,0));
        vecs.push_back(mv(1,1,1,1,32'h0BADF00D,0, 3'd5,32'h0,       0,0,1,0));
        vecs.push_back(mv(1,1,1,1,32'h0BADF00D,0, 3'd6,32'h0,       0,1,1,0));
        vecs.push_back(mv(1,1,1,1,32'h0BADF00D,0, 3'd6,32'h0,       0,1,1,0));
        vecs.push_back(mv(1,0,0,1,32'h0,       0, 3'd0,32'hDEADBEEF,1,1,0,0));
        vecs.push_back(mv(1,0,0,1,32'h0,       0, 3'd0,32'h0,       0,1,0,0));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rn, vecs[i].iso, vecs[i].ret, vecs[i].pse, vecs[i].s, vecs[i].c);
            expect_out($sformatf("v%0d", i), vecs[i].st, vecs[i].so, vecs[i].co,
                       vecs[i].pg, vecs[i].rv, vecs[i].pe);
        end

        // pse drop while ON: error, no save, restore cycle drives the clamp value
        step(1,0,0,0,32'h55555555,1);
        expect_out("err.down0", 3'd3, 32'h0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(1,0,0,0,32'h55555555,1);
        expect_out("err.down3", 3'd3, 32'h0, 0, 0, 0, 1);
        step(1,0,0,0,32'h55555555,1);
        expect_out("err.off", 3'd4, 32'h0, 0, 0, 0, 1);
        step(1,0,0,1,32'h55555555,1);
        expect_out("err.up0", 3'd5, 32'h0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(1,0,0,1,32'h55555555,1);
        expect_out("err.up3", 3'd5, 32'h0, 0, 0, 0, 1);
        step(1,0,0,1,32'h55555555,1);
        expect_out("err.ready", 3'd6, 32'h0, 0, 1, 0, 1);
        step(1,0,0,1,32'h55555555,1);
        expect_out("err.restore", 3'd0, 32'h0, 0, 1, 0, 1);
        step(1,0,0,1,32'h55555555,1);
        expect_out("err.live", 3'd0, 32'h55555555, 1, 1, 0, 1);

        // reset while OFF with a retained value
        step(0,0,0,1,32'h0,0);
        expect_out("rst.clear", 3'd0, 32'h0, 0, 1, 0, 0);
        step(1,1,0,1,32'h77777777,1);
        step(1,1,1,1,32'h77777777,1);
        expect_out("rst.ret", 3'd2, 32'h0, 0, 1, 1, 0);
        for (int i = 0; i < 5; i++) step(1,1,1,0,32'h77777777,1);
        expect_out("rst.off", 3'd4, 32'h0, 0, 0, 1, 0);
        step(0,1,1,0,32'h77777777,1);
        expect_out("rst.on", 3'd0, 32'h0, 0, 1, 0, 0);
        step(1,0,0,1,32'h01020304,0);
        expect_out("rst.live", 3'd0, 32'h01020304, 0, 1, 0, 0);

        // pse back high mid-DOWN: ramp still finishes, then full UP ramp
        step(1,1,0,1,32'h0,0);
        step(1,1,1,1,32'hCAFEF00D,0);
        step(1,1,1,0,32'h0,0);
        expect_out("ramp.d0", 3'd3, 32'h0, 0, 0, 1, 0);
        step(1,1,1,1,32'h0,0);
        expect_out("ramp.d1", 3'd3, 32'h0, 0, 0, 1, 0);
        step(1,1,1,1,32'h0,0);
        step(1,1,1,1,32'h0,0);
        expect_out("ramp.d3", 3'd3, 32'h0, 0, 0, 1, 0);
        step(1,1,1,1,32'h0,0);
        expect_out("ramp.off", 3'd4, 32'h0, 0, 0, 1, 0);
        step(1,1,1,1,32'h0,0);
        expect_out("ramp.u0", 3'd5, 32'h0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(1,1,1,1,32'h0,0);
        expect_out("ramp.u3", 3'd5, 32'h0, 0, 0, 1, 0);
        step(1,1,1,1,32'h0,0);
        expect_out("ramp.ready", 3'd6, 32'h0, 0, 1, 1, 0);

        // pse drop during UP aborts back to DOWN with a fresh ramp
        for (int i = 0; i < 5; i++) step(1,1,1,0,32'h0,0);
        expect_out("abort.off", 3'd4, 32'h0, 0, 0, 1, 0);
        step(1,1,1,1,32'h0,0);
        step(1,1,1,1,32'h0,0);
        expect_out("abort.u1", 3'd5, 32'h0, 0, 0, 1, 0);
        step(1,1,1,0,32'h0,0);
        expect_out("abort.down", 3'd3, 32'h0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(1,1,1,1,32'h0,0);
        expect_out("abort.d3", 3'd3, 32'h0, 0, 0, 1, 0);
        step(1,1,1,1,32'h0,0);
        expect_out("abort.off2", 3'd4, 32'h0, 0, 0, 1, 0);

        // retained value from this save comes back after the power cycle
        for (int i = 0; i < 5; i++) step(1,1,1,1,32'h0,0);
        expect_out("abort.ready", 3'd6, 32'h0, 0, 1, 1, 0);
        step(1,0,0,1,32'h0,0);
        expect_out("abort.restore", 3'd0, 32'hCAFEF00D, 0, 1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
